med_rank_filter: RTL and testbench

- Self-sequenced order-statistic filter: collects a window of LENGTH unsigned samples, then returns the sample of a chosen rank (max, median, min or anything between).
- Internal FSM and counters replace the externally driven load/bypass sequencing of the earlier median datapath.
- Valid/ready handshakes on both sides, so it drops between a pixel/sample stream source and a downstream consumer without glue logic.
- Datapath: LENGTH-deep register ring plus one compare-exchange cell; no sorting network.

---
 rtl/med_rank_filter.sv | 160 ++++++++++++++++
 tb/tb_med_rank_filter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/med_rank_filter.sv
// Order-statistic filter: collects LENGTH samples, then returns the sample of a chosen rank (0 = largest).
// Latency: the last accept at edge t0 gives DO_VALID high after edge t0 + (rank+1)*LENGTH.
// Backpressure: DI_RDY is low outside LOAD; DO/DO_VALID hold until DO_RDY is seen, then the FSM returns to LOAD.
//
// Ports:
//   CLK, nRST           clock (rising edge) and asynchronous active-low reset
//   DI, DSI, DI_RDY     input sample, valid and ready; a sample is accepted when DSI & DI_RDY
//   RANK                rank to select, latched with the first sample of each window and clamped to LENGTH-1
//   DO, DO_VALID, DO_RDY  result, valid and downstream ready; the result is consumed when DO_VALID & DO_RDY
//   BUSY                high while the window is being ranked or the result is waiting
module med_rank_filter #(
    parameter int SIZE   = 8,
    parameter int LENGTH = 9,
    parameter int RW     = $clog2(LENGTH)
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [SIZE-1:0] DI,
    input  logic            DSI,
    output logic            DI_RDY,
    input  logic [RW-1:0]   RANK,
    output logic [SIZE-1:0] DO,
    output logic            DO_VALID,
    input  logic            DO_RDY,
    output logic            BUSY
);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_OUT     = 2'd2
    } state_t;

    localparam logic [RW-1:0] LAST = RW'(LENGTH - 1);

    state_t          state;
    logic [RW-1:0]   cnt;       // sample count in LOAD, cycle-in-pass in COMPUTE
    logic [RW-1:0]   pass;
    logic [RW-1:0]   rank_q;
    logic [SIZE-1:0] do_q;
    logic            do_vld_q;
    logic            busy_q;

    // Sample ring. Position 0 is the head and holds the running maximum of the
    // current pass. xf marks entries already extracted by earlier passes.
    logic [SIZE-1:0] ring [LENGTH];
    logic [LENGTH-1:0] xf;

    logic            accept;
    logic            last_cyc;
    logic [RW-1:0]   rank_in;
    logic            swap;
    logic [SIZE-1:0] head_nxt;
    logic [SIZE-1:0] tail_nxt;
    logic            head_x;
    logic            tail_x;

    assign DI_RDY   = nRST && (state == S_LOAD);
    assign accept   = DSI && DI_RDY;
    assign last_cyc = (cnt == LAST);
    assign DO       = do_q;
    assign DO_VALID = do_vld_q;
    assign BUSY     = busy_q;

    // The comparison is done one bit wider so that LENGTH itself is always representable.
    assign rank_in = ({1'b0, RANK} >= (RW+1)'(LENGTH)) ? LAST : RANK;

    // Compare-exchange between the head and the entry about to pass it. The
    // larger unextracted value stays at the head, and the other value drops to
    // the tail. An extracted head always yields to an unextracted
    // entry, and an extracted entry never displaces the head. On a tie nothing
    // moves.
    always_comb begin
        swap     = !xf[1] && (xf[0] || (ring[1] > ring[0]));
        head_nxt = swap ? ring[1] : ring[0];
        head_x   = swap ? xf[1]   : xf[0];
        tail_nxt = swap ? ring[0] : ring[1];
        tail_x   = swap ? xf[0]   : xf[1];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= S_LOAD;
            cnt      <= '0;
            pass     <= '0;
            rank_q   <= '0;
            do_q     <= '0;
            do_vld_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        if (cnt == '0) begin
                            rank_q <= rank_in;
                        end
                        if (last_cyc) begin
                            cnt    <= '0;
                            pass   <= '0;
                            busy_q <= 1'b1;
                            state  <= S_COMPUTE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (last_cyc) begin
                        cnt <= '0;
                        if (pass == rank_q) begin
                            do_q     <= head_nxt;
                            do_vld_q <= 1'b1;
                            state    <= S_OUT;
                        end else begin
                            pass <= pass + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    if (DO_RDY) begin
                        do_vld_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state    <= S_LOAD;
                    end
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

    // The ring contents are don't-care after reset, because every window
    // refills all LENGTH entries and clears their extracted flags.
    always_ff @(posedge CLK) begin
        if (accept) begin
            for (int i = 0; i < LENGTH - 1; i++) begin
                ring[i] <= ring[i+1];
                xf[i]   <= xf[i+1];
            end
            ring[LENGTH-1] <= DI;
            xf[LENGTH-1]   <= 1'b0;
        end else if (state == S_COMPUTE) begin
            // Entries 1..LENGTH-1 rotate past the head. After LENGTH cycles
            // the head holds the largest unextracted value. It is flagged on
            // the last cycle so that the next pass skips it.
            ring[0] <= head_nxt;
            xf[0]   <= head_x | last_cyc;
            for (int i = 1; i < LENGTH - 1; i++) begin
                ring[i] <= ring[i+1];
                xf[i]   <= xf[i+1];
            end
            ring[LENGTH-1] <= tail_nxt;
            xf[LENGTH-1]   <= tail_x;
        end
    end

endmodule

// File: tb/tb_med_rank_filter.sv
module tb_med_rank_filter;

    typedef logic [7:0] win_t [9];

    logic       CLK;
    logic       nRST;
    logic [7:0] DI;
    logic       DSI;
    logic       DI_RDY;
    logic [3:0] RANK;
    logic [7:0] DO;
    logic       DO_VALID;
    logic       DO_RDY;
    logic       BUSY;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    med_rank_filter #(.SIZE(8), .LENGTH(9)) dut (
        .CLK(CLK), .nRST(nRST), .DI(DI), .DSI(DSI), .DI_RDY(DI_RDY), .RANK(RANK),
        .DO(DO), .DO_VALID(DO_VALID), .DO_RDY(DO_RDY), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Reference: sort the window in descending order and index it with the clamped rank.
    function automatic int model(input win_t s, input int rank);
        int q[$];
        int r;
        foreach (s[i]) q.push_back(int'(s[i]));
        q.rsort();
        r = (rank > 8) ? 8 : rank;
        return q[r];
    endfunction

    // Feeds one window. gap inserts an idle cycle before each sample, and
    // wiggle randomises RANK after the first sample.
    task automatic load_window(input win_t s, input int rank, input bit gap, input bit wiggle,
                               output int t_last, output bit to);
        to = 0;
        t_last = 0;
        for (int i = 0; i < 9; i++) begin
            bit done;
            int n;
            done = 0;
            n = 0;
            if (gap) begin
                @(negedge CLK);
                DSI = 1'b0;
                DI = 8'($urandom);
            end
            while (!done && n < 200) begin
                @(negedge CLK);
                DI = s[i];
                DSI = 1'b1;
                if (wiggle && i > 0) RANK = 4'($urandom);
                else RANK = 4'(rank);
                done = (DI_RDY === 1'b1);
                @(posedge CLK);
                #1;
                n++;
            end
            if (!done) to = 1;
            t_last = cyc;
        end
        @(negedge CLK);
        DSI = 1'b0;
    endtask

    task automatic wait_valid(output int t, output bit to, output bit busy_ok);
        to = 1;
        busy_ok = 1;
        t = 0;
        for (int n = 0; n < 1000; n++) begin
            @(posedge CLK);
            #1;
            if (BUSY !== 1'b1 || DI_RDY !== 1'b0) busy_ok = 0;
            if (DO_VALID === 1'b1) begin
                t = cyc;
                to = 0;
                break;
            end
        end
    endtask

    task automatic run(input win_t s, input int rank, input bit gap, input bit wiggle,
                       output int lat, output logic [7:0] dout, output bit to, output bit busy_ok);
        int t0;
        int t1;
        bit to_a;
        bit to_b;
        load_window(s, rank, gap, wiggle, t0, to_a);
        wait_valid(t1, to_b, busy_ok);
        lat = t1 - t0;
        dout = DO;
        to = to_a | to_b;
    endtask

    task automatic consume(output logic vld_after, output logic rdy_after, output logic [7:0] do_after);
        @(negedge CLK);
        DO_RDY = 1'b1;
        @(posedge CLK);
        #1;
        vld_after = DO_VALID;
        rdy_after = DI_RDY;
        do_after = DO;
        @(negedge CLK);
        DO_RDY = 1'b0;
    endtask

    task automatic test_reset;
        nRST = 1'b0;
        #12;
        checks++;
        if (DO !== 8'd0 || DO_VALID !== 1'b0 || BUSY !== 1'b0 || DI_RDY !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: DO=%0d DO_VALID=%b BUSY=%b DI_RDY=%b expected 0 0 0 0", DO, DO_VALID, BUSY, DI_RDY);
        end
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        checks++;
        if (DI_RDY !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_rdy: DI_RDY=%b expected 1", DI_RDY);
        end
    endtask

    task automatic test_median;
        win_t s = '{8'd7, 8'd3, 8'd9, 8'd1, 8'd5, 8'd8, 8'd2, 8'd6, 8'd4};
        int lat;
        logic [7:0] d;
        logic v;
        logic r;
        logic [7:0] dk;
        bit to;
        bit bok;
        run(s, 4, 0, 0, lat, d, to, bok);
        checks++;
        if (to || d !== 8'(model(s, 4))) begin
            errors++;
            $display("FAIL median_do: got %0d (timeout=%0d) expected %0d", d, to, model(s, 4));
        end
        checks++;
        if (lat !== 45) begin
            errors++;
            $display("FAIL median_latency: got %0d expected 45", lat);
        end
        checks++;
        if (!bok) begin
            errors++;
            $display("FAIL median_busy: BUSY/DI_RDY not 1/0 during compute, got flag %0d expected 1", bok);
        end
        consume(v, r, dk);
        checks++;
        if (v !== 1'b0 || r !== 1'b1 || dk !== 8'd5 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL median_consume: DO_VALID=%b DI_RDY=%b DO=%0d BUSY=%b expected 0 1 5 0", v, r, dk, BUSY);
        end
    endtask

    task automatic test_ranks;
        win_t s = '{8'd7, 8'd3, 8'd9, 8'd1, 8'd5, 8'd8, 8'd2, 8'd6, 8'd4};
        int rk[3] = '{0, 8, 12};
        int el[3] = '{9, 81, 81};
        int ev[3] = '{9, 1, 1};
        for (int k = 0; k < 3; k++) begin
            int lat;
            logic [7:0] d;
            logic v;
            logic r;
            logic [7:0] dk;
            bit to;
            bit bok;
            run(s, rk[k], 0, 0, lat, d, to, bok);
            checks++;
            if (to || d !== 8'(ev[k]) || lat !== el[k]) begin
                errors++;
                $display("FAIL rank_%0d: DO=%0d latency=%0d expected DO=%0d latency=%0d", rk[k], d, lat, ev[k], el[k]);
            end
            consume(v, r, dk);
        end
    endtask

    task automatic test_duplicates;
        win_t s1 = '{8'd4, 8'd4, 8'd4, 8'd2, 8'd2, 8'd9, 8'd9, 8'd9, 8'd9};
        win_t s2 = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        int lat;
        logic [7:0] d;
        logic v;
        logic r;
        logic [7:0] dk;
        bit to;
        bit bok;
        run(s1, 4, 0, 0, lat, d, to, bok);
        checks++;
        if (to || d !== 8'd4) begin
            errors++;
            $display("FAIL dup_median: got %0d expected 4", d);
        end
        consume(v, r, dk);
        run(s2, 4, 0, 0, lat, d, to, bok);
        checks++;
        if (to || d !== 8'd255) begin
            errors++;
            $display("FAIL dup_all255: got %0d expected 255", d);
        end
        consume(v, r, dk);
    endtask

    task automatic test_backpressure;
        win_t s = '{8'd10, 8'd80, 8'd30, 8'd70, 8'd50, 8'd20, 8'd60, 8'd40, 8'd90};
        win_t f;
        int lat;
        logic [7:0] d;
        logic v;
        logic r;
        logic [7:0] dk;
        bit to;
        bit bok;
        bit stable;
        run(s, 2, 0, 0, lat, d, to, bok);
        checks++;
        if (to || d !== 8'd70) begin
            errors++;
            $display("FAIL bp_result: got %0d expected 70", d);
        end
        stable = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            DSI = 1'($urandom);
            DI = 8'($urandom);
            #1;
            if (DO_VALID !== 1'b1 || DO !== 8'd70 || DI_RDY !== 1'b0) stable = 0;
        end
        @(negedge CLK);
        DSI = 1'b0;
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL bp_hold: DO_VALID=%b DO=%0d DI_RDY=%b expected 1 70 0 throughout", DO_VALID, DO, DI_RDY);
        end
        consume(v, r, dk);
        foreach (f[i]) f[i] = 8'($urandom);
        run(f, 4, 0, 0, lat, d, to, bok);
        checks++;
        if (to || d !== 8'(model(f, 4))) begin
            errors++;
            $display("FAIL bp_fresh_window: got %0d expected %0d", d, model(f, 4));
        end
        consume(v, r, dk);
    endtask

    task automatic test_dsi_toggle;
        win_t s = '{8'd7, 8'd3, 8'd9, 8'd1, 8'd5, 8'd8, 8'd2, 8'd6, 8'd4};
        int lat;
        logic [7:0] d;
        bit to;
        bit bok;
        run(s, 4, 1, 1, lat, d, to, bok);
        checks++;
        if (to || d !== 8'd5 || lat !== 45) begin
            errors++;
            $display("FAIL dsi_toggle: DO=%0d latency=%0d expected DO=5 latency=45", d, lat);
        end
        // The result is left pending so that the next test starts from a nonzero DO.
    endtask

    task automatic test_reset_mid_compute;
        win_t s = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88, 8'd99};
        int t0;
        int lat;
        logic [7:0] d;
        logic v;
        logic r;
        logic [7:0] dk;
        bit to;
        bit bok;
        bit seen;
        consume(v, r, dk);
        load_window(s, 6, 0, 0, t0, to);
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if (DO !== 8'd0 || DO_VALID !== 1'b0 || BUSY !== 1'b0 || DI_RDY !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: DO=%0d DO_VALID=%b BUSY=%b DI_RDY=%b expected 0 0 0 0", DO, DO_VALID, BUSY, DI_RDY);
        end
        @(negedge CLK);
        nRST = 1'b1;
        seen = 0;
        repeat (80) begin
            @(posedge CLK);
            #1;
            if (DO_VALID !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_mid_no_output: DO_VALID rose after abort, expected it to stay 0");
        end
        run(s, 6, 0, 0, lat, d, to, bok);
        checks++;
        if (to || d !== 8'd33 || lat !== 63) begin
            errors++;
            $display("FAIL rst_mid_recover: DO=%0d latency=%0d expected DO=33 latency=63", d, lat);
        end
        consume(v, r, dk);
    endtask

    task automatic test_random;
        for (int k = 0; k < 14; k++) begin
            win_t s;
            int rk;
            int lat;
            int elat;
            logic [7:0] d;
            logic v;
            logic r;
            logic [7:0] dk;
            bit to;
            bit bok;
            foreach (s[i]) s[i] = (k % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            rk = int'($urandom_range(0, 15));
            elat = ((rk > 8) ? 9 : rk + 1) * 9;
            run(s, rk, k % 3 == 0, 0, lat, d, to, bok);
            checks++;
            if (to || d !== 8'(model(s, rk)) || lat !== elat || !bok) begin
                errors++;
                $display("FAIL random_%0d: DO=%0d latency=%0d busy_ok=%0d expected DO=%0d latency=%0d busy_ok=1",
                         k, d, lat, bok, model(s, rk), elat);
            end
            consume(v, r, dk);
        end
    endtask

    initial begin
        nRST = 1'b0;
        DI = 8'd0;
        DSI = 1'b0;
        RANK = 4'd0;
        DO_RDY = 1'b0;
        test_reset();
        test_median();
        test_ranks();
        test_duplicates();
        test_backpressure();
        test_dsi_toggle();
        test_reset_mid_compute();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
